// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: region decode with registered chip selects, DTACK wait
// states, BERR on unmapped/read-only-write or timeout, and VPA for IACK cycles.
module m68k_bus_ctrl #(
  parameter int                              NUM_REGIONS  = 3,
  parameter int                              DEC_BITS     = 4,
  parameter logic [NUM_REGIONS*DEC_BITS-1:0] REGION_BASE  = {4'hE, 4'hC, 4'h0},
  parameter logic [NUM_REGIONS*4-1:0]        WAIT_STATES  = {4'd0, 4'd0, 4'd2},
  parameter logic [NUM_REGIONS-1:0]          RO_MASK      = 3'b001,
  parameter int                              BERR_TIMEOUT = 64
) (
  input  logic                   cpu_clk,
  input  logic                   reset,
  input  logic [23:0]            addr,
  input  logic                   as,
  input  logic                   rw,
  input  logic [2:0]             fc,
  input  logic                   lds,
  input  logic                   uds,
  output logic [NUM_REGIONS-1:0] cs_n,
  output logic                   dtack,
  output logic                   berr,
  output logic                   vpa
);

  localparam int              TO_W    = $clog2(BERR_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_FIRE = TO_W'(BERR_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACK, S_ERR, S_IACK, S_END
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_hit;
  logic [3:0]               r_wcnt;
  logic [TO_W-1:0]          r_to;

  logic [DEC_BITS-1:0]      w_dec_code;
  logic                     w_dec_hit;
  logic [NUM_REGIONS-1:0]   w_dec_sel;
  logic [3:0]               w_dec_ws;
  logic                     w_dec_ro;
  logic                     w_start;
  logic                     w_iack;
  logic                     w_ws_done;
  logic                     w_to_fire;
  logic                     w_unused;

  logic [NUM_REGIONS-1:0]   w_cs_n_nxt;
  logic                     w_dtack_nxt;
  logic                     w_berr_nxt;
  logic                     w_vpa_nxt;

  assign w_dec_code = addr[23 -: DEC_BITS];
  assign w_unused   = ^addr[23-DEC_BITS:0];

  // Walk from the top index down so the lowest matching region wins.
  always_comb begin
    w_dec_hit = 1'b0;
    w_dec_sel = '0;
    w_dec_ws  = 4'd0;
    w_dec_ro  = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (w_dec_code == REGION_BASE[i*DEC_BITS +: DEC_BITS]) begin
        w_dec_hit    = 1'b1;
        w_dec_sel    = '0;
        w_dec_sel[i] = 1'b1;
        w_dec_ws     = WAIT_STATES[i*4 +: 4];
        w_dec_ro     = RO_MASK[i];
      end
    end
  end

  assign w_start   = (r_state == S_IDLE) && !as && (!lds || !uds);
  assign w_iack    = (fc == 3'b111);
  assign w_ws_done = (r_wcnt == 4'd0);
  assign w_to_fire = (r_to == TO_FIRE);

  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_END;
      cs_n    <= '1;
      dtack   <= 1'b1;
      berr    <= 1'b1;
      vpa     <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      cs_n    <= w_cs_n_nxt;
      dtack   <= w_dtack_nxt;
      berr    <= w_berr_nxt;
      vpa     <= w_vpa_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          if (w_iack)                          w_state_nxt = S_IACK;
          else if (w_dec_hit && w_dec_ro && !rw) w_state_nxt = S_ERR;
          else                                 w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (as)                          w_state_nxt = S_IDLE;
        else if (r_hit && w_ws_done)     w_state_nxt = S_ACK;
        else if (!r_hit && w_to_fire)    w_state_nxt = S_ERR;
      end
      S_ACK, S_ERR, S_IACK, S_END: begin
        if (as) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next registered output values; asserted strobes hold until AS is seen high.
  always_comb begin
    w_cs_n_nxt  = cs_n;
    w_dtack_nxt = dtack;
    w_berr_nxt  = berr;
    w_vpa_nxt   = vpa;
    case (r_state)
      S_IDLE: begin
        w_cs_n_nxt  = '1;
        w_dtack_nxt = 1'b1;
        w_berr_nxt  = 1'b1;
        w_vpa_nxt   = 1'b1;
        if (w_start) begin
          if (w_iack)                            w_vpa_nxt  = 1'b0;
          else if (w_dec_hit && w_dec_ro && !rw) w_berr_nxt = 1'b0;
          else                                   w_cs_n_nxt = ~w_dec_sel;
        end
      end
      S_WAIT: begin
        if (as) begin
          w_cs_n_nxt  = '1;
          w_dtack_nxt = 1'b1;
          w_berr_nxt  = 1'b1;
          w_vpa_nxt   = 1'b1;
        end else if (r_hit && w_ws_done) begin
          w_dtack_nxt = 1'b0;
        end else if (!r_hit && w_to_fire) begin
          w_berr_nxt = 1'b0;
        end
      end
      S_ACK, S_ERR, S_IACK: begin
        if (as) begin
          w_cs_n_nxt  = '1;
          w_dtack_nxt = 1'b1;
          w_berr_nxt  = 1'b1;
          w_vpa_nxt   = 1'b1;
        end
      end
      default: begin
        w_cs_n_nxt  = '1;
        w_dtack_nxt = 1'b1;
        w_berr_nxt  = 1'b1;
        w_vpa_nxt   = 1'b1;
      end
    endcase
  end

  // Wait-state and timeout counters; the timeout saturates instead of wrapping.
  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      r_hit  <= 1'b0;
      r_wcnt <= 4'd0;
      r_to   <= '0;
    end else if (w_start) begin
      r_hit  <= w_dec_hit;
      r_wcnt <= w_dec_ws;
      r_to   <= '0;
    end else if (r_state == S_WAIT) begin
      if (!w_ws_done) r_wcnt <= r_wcnt - 4'd1;
      if (!as && (r_to != '1)) r_to <= r_to + 1'b1;
    end
  end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: decode, wait states, BERR, VPA, abort and reset.
module tb_m68k_bus_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic [23:0] addr;
  logic        as;
  logic        rw;
  logic [2:0]  fc;
  logic        lds;
  logic        uds;
  logic [2:0]  cs_n;
  logic        dtack;
  logic        berr;
  logic        vpa;

  int checks = 0;
  int errors = 0;

  m68k_bus_ctrl dut (
    .cpu_clk (cpu_clk),
    .reset   (reset),
    .addr    (addr),
    .as      (as),
    .rw      (rw),
    .fc      (fc),
    .lds     (lds),
    .uds     (uds),
    .cs_n    (cs_n),
    .dtack   (dtack),
    .berr    (berr),
    .vpa     (vpa)
  );

  always #5 cpu_clk = ~cpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_cs, input logic e_dt,
                         input logic e_be, input logic e_vp);
    chk({tag, ".cs_n"},  {29'd0, cs_n}, {29'd0, e_cs});
    chk({tag, ".dtack"}, {31'd0, dtack}, {31'd0, e_dt});
    chk({tag, ".berr"},  {31'd0, berr},  {31'd0, e_be});
    chk({tag, ".vpa"},   {31'd0, vpa},   {31'd0, e_vp});
  endtask

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic begin_cycle(input logic [23:0] a, input logic r, input logic [2:0] f);
    addr = a;
    rw   = r;
    fc   = f;
    as   = 1'b0;
    lds  = 1'b0;
    uds  = 1'b0;
  endtask

  task automatic end_cycle();
    as  = 1'b1;
    lds = 1'b1;
    uds = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    addr  = 24'd0;
    as    = 1'b1;
    rw    = 1'b1;
    fc    = 3'b000;
    lds   = 1'b1;
    uds   = 1'b1;
    #2 reset = 1'b0;
    #1 chk_all("reset", 3'b111, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_all("post_reset_idle", 3'b111, 1'b1, 1'b1, 1'b1);

    // ROM read, 2 wait states: DTACK on the third edge after the latch edge
    begin_cycle(24'h000010, 1'b1, 3'b110);
    tick();
    chk_all("rom_rd_latch", 3'b110, 1'b1, 1'b1, 1'b1);
    tick();
    chk("rom_rd_e1_dtack", {31'd0, dtack}, 32'd1);
    tick();
    chk("rom_rd_e2_dtack", {31'd0, dtack}, 32'd1);
    tick();
    chk_all("rom_rd_e3", 3'b110, 1'b0, 1'b1, 1'b1);
    tick();
    chk_all("rom_rd_hold", 3'b110, 1'b0, 1'b1, 1'b1);
    end_cycle();
    tick();
    chk_all("rom_rd_release", 3'b111, 1'b1, 1'b1, 1'b1);

    // AS low without a data strobe does not start a cycle
    addr = 24'hC00000; rw = 1'b0; fc = 3'b101; as = 1'b0;
    tick();
    chk_all("no_strobe", 3'b111, 1'b1, 1'b1, 1'b1);
    lds = 1'b0;
    tick();
    chk_all("ram1_wr_latch", 3'b101, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("ram1_wr_e1", 3'b101, 1'b0, 1'b1, 1'b1);
    end_cycle();
    tick();
    chk_all("ram1_wr_release", 3'b111, 1'b1, 1'b1, 1'b1);

    begin_cycle(24'hE12344, 1'b0, 3'b101);
    uds = 1'b1;
    tick();
    chk_all("ram2_wr_latch", 3'b011, 1'b1, 1'b1, 1'b1);
    tick();
    chk_all("ram2_wr_e1", 3'b011, 1'b0, 1'b1, 1'b1);
    end_cycle();
    tick();
    chk_all("ram2_wr_release", 3'b111, 1'b1, 1'b1, 1'b1);

    // Write to read-only ROM: immediate BERR, no chip select
    begin_cycle(24'h000100, 1'b0, 3'b101);
    tick();
    chk_all("rom_wr_latch", 3'b111, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("rom_wr_hold", 3'b111, 1'b1, 1'b0, 1'b1);
    end
    end_cycle();
    tick();
    chk_all("rom_wr_release", 3'b111, 1'b1, 1'b1, 1'b1);

    // Unmapped read: BERR on the 64th edge with AS low (latch + 63)
    begin_cycle(24'h500000, 1'b1, 3'b101);
    tick();
    chk_all("unmap_latch", 3'b111, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 62; k++) begin
      tick();
      chk("unmap_wait_berr", {31'd0, berr}, 32'd1);
      chk("unmap_wait_dtack", {31'd0, dtack}, 32'd1);
    end
    tick();
    chk_all("unmap_timeout", 3'b111, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("unmap_timeout_hold", 3'b111, 1'b1, 1'b0, 1'b1);
    end_cycle();
    tick();
    chk_all("unmap_release", 3'b111, 1'b1, 1'b1, 1'b1);

    // Unmapped read aborted at edge 30: no BERR ever
    begin_cycle(24'h500000, 1'b1, 3'b101);
    tick();
    for (int k = 1; k <= 29; k++) tick();
    chk("abort_pre_berr", {31'd0, berr}, 32'd1);
    end_cycle();
    tick();
    chk_all("abort_edge", 3'b111, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 40; k++) tick();
    chk_all("abort_quiet", 3'b111, 1'b1, 1'b1, 1'b1);

    // Interrupt acknowledge: VPA at the latch edge, no chip select
    begin_cycle(24'hFFFFF5, 1'b1, 3'b111);
    tick();
    chk_all("iack_latch", 3'b111, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("iack_hold", 3'b111, 1'b1, 1'b1, 1'b0);
    end_cycle();
    tick();
    chk_all("iack_release", 3'b111, 1'b1, 1'b1, 1'b1);

    // Reset in the middle of a wait-state cycle with AS held low
    begin_cycle(24'h000010, 1'b1, 3'b110);
    tick();
    chk("rst_mid_latch", {29'd0, cs_n}, 32'd6);
    tick();
    #2 reset = 1'b0;
    #1 chk_all("rst_mid_async", 3'b111, 1'b1, 1'b1, 1'b1);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all("rst_end_hold", 3'b111, 1'b1, 1'b1, 1'b1);
    end
    end_cycle();
    tick();
    chk_all("rst_end_idle", 3'b111, 1'b1, 1'b1, 1'b1);
    begin_cycle(24'h000010, 1'b1, 3'b110);
    tick();
    chk_all("rst_new_latch", 3'b110, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    chk("rst_new_e2_dtack", {31'd0, dtack}, 32'd1);
    tick();
    chk_all("rst_new_e3", 3'b110, 1'b0, 1'b1, 1'b1);
    end_cycle();
    tick();
    chk_all("rst_new_release", 3'b111, 1'b1, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_ctrl.md
Name: m68k_bus_ctrl

Overview:
Parametrised 68000 bus controller that replaces the plain chip-select decoder. It decodes NUM_REGIONS address regions on the top DEC_BITS address lines and registers chip selects on cpu_clk. It generates DTACK with per-region wait states, BERR on unmapped access or write to a read-only region, and VPA for interrupt-acknowledge cycles. It sits between the CPU bus and the RAM/ROM chip enables.

Parameters:
NUM_REGIONS, 3, number of decoded regions / chip selects
DEC_BITS, 4, decoded address bits, addr[23:24-DEC_BITS]
REGION_BASE, {4'hE,4'hC,4'h0}, packed NUM_REGIONS*DEC_BITS match codes; region i in bits [i*DEC_BITS +: DEC_BITS]
WAIT_STATES, {4'd0,4'd0,4'd2}, packed NUM_REGIONS*4 wait cycles per region (0..15)
RO_MASK, 3'b001, bit i=1 marks region i read-only
BERR_TIMEOUT, 64, cycles with AS low and no DTACK/VPA before BERR (range 2..1023)

Ports:
cpu_clk  input  1  CPU clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
addr  input  24  CPU address bus
as  input  1  address strobe, active-low
rw  input  1  1=read, 0=write
fc  input  3  function code
lds  input  1  lower data strobe, active-low (qualifies the cycle only)
uds  input  1  upper data strobe, active-low (qualifies the cycle only)
cs_n  output  NUM_REGIONS  per-region chip select, active-low
dtack  output  1  data transfer acknowledge, active-low
berr  output  1  bus error, active-low
vpa  output  1  valid peripheral address / autovector, active-low

Behaviour:
- Reset is asserted (reset=0, asynchronous): cs_n all 1, dtack=1, berr=1, vpa=1. The FSM goes to END.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, WAIT, ACK, ERR, IACK, END.
- IDLE: on an edge with as=0 and (lds=0 or uds=0), latch addr[23:24-DEC_BITS], rw and fc, then classify:
  - fc==3'b111 (IACK): go to IACK; vpa=0 at this same edge; no cs.
  - Region hit, lowest index wins if several match:
    - RO_MASK[i]=1 and rw=0: go to ERR; berr=0 at this edge; cs_n stays 1.
    - Otherwise: cs_n[i]=0 at this edge; load wait counter with WAIT_STATES[i]; go to WAIT (or straight to ACK with dtack=0 at the next edge if WAIT_STATES[i]==0).
  - No hit: go to WAIT with no cs asserted; only the timeout can end the cycle.
- WAIT:
  - The counter decrements each edge.
  - Hit cycle: dtack=0 on the edge where the counter reaches 0, then go to ACK. DTACK latency from the latch edge = WAIT_STATES[i]+1 edges.
  - Timeout counter: cleared at the latch edge and incremented every edge while as=0. If it reaches BERR_TIMEOUT-1 before DTACK (unmapped case), berr=0 and go to ERR.
  - The timeout counter is wide enough for BERR_TIMEOUT and saturates; it never wraps.
- ACK, ERR, IACK: hold the asserted outputs until an edge samples as=1. At that edge all outputs return to 1 and the FSM goes to IDLE. A new cycle cannot start on that same edge.
- as rising early (as=1 sampled in WAIT): abort the cycle, cs_n all 1, dtack/berr/vpa stay 1, go to IDLE.
- END: wait for an edge sampling as=1, then go to IDLE. This prevents decoding a cycle already in progress when reset releases.
- dtack, berr and vpa are never asserted together. cs_n has at most one bit low.
- lds/uds do not affect the decode beyond qualifying cycle start.

Test Plan:
- Read addr=24'h0000_10, fc=3'b110: cs_n=3'b110 at the latch edge, dtack=0 exactly 3 edges after latch; as high -> all outputs 1 on the next edge.
- Write addr=24'hC0_0000: cs_n=3'b101 at the latch edge, dtack=0 one edge later. Write addr=24'hE1_2344: cs_n=3'b011, same timing.
- Write addr=24'h00_0100 (ROM, read-only): berr=0 at the latch edge, cs_n stays 3'b111, dtack stays 1, held until as rises.
- Read addr=24'h50_0000 (unmapped): no cs, dtack stays 1, berr=0 after 64 edges with as low; an abort at edge 30 produces no berr.
- IACK cycle fc=3'b111, addr=24'hFFFFF5: vpa=0 at the latch edge, cs_n=3'b111; vpa released when as=1.
- Reset pulse mid-WAIT with as held low: outputs go to 1 immediately; after release no cs/dtack until as goes high then low again.
